// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up and exception flags in a final cycle.
module multdiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic             multRDY,
    output logic             divRDY
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic             prev_mult, prev_div;
    logic             start_mul, start_div;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             op_mul, op_mul_nx;
    logic             sgn, sgn_nx;
    logic             neg_a, neg_a_nx;
    logic             neg_b, neg_b_nx;
    logic             dbz, dbz_nx;
    logic [WIDTH-1:0] opnd_mag, opnd_mag_nx;
    logic [WIDTH-1:0] acc_hi, acc_hi_nx;
    logic [WIDTH-1:0] acc_lo, acc_lo_nx;

    logic [WIDTH-1:0] result_nx, result_hi_nx;
    logic             exception_nx, result_rdy_nx, busy_nx, mult_rdy_nx, div_rdy_nx;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [W2-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             mul_ovf, div_ovf;

    // Rising-edge start detection on the level control inputs
    assign start_mul = ctrl_MULT & ~prev_mult;
    assign start_div = ctrl_DIV & ~prev_div;

    // Operand magnitudes taken at the start edge
    assign a_mag = (ctrl_signed & data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
    assign b_mag = (ctrl_signed & data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;

    // One multiply step: conditional add of multiplicand, then shift right
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_mag} : {(WIDTH+1){1'b0}});

    // One divide step: shift remainder left, trial subtract divisor
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_mag};
    assign div_diff  = WIDTH'(div_shift - {1'b0, opnd_mag});

    // Sign fix-up and exception detection used in the final cycle
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    assign quo_fix  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    assign rem_fix  = neg_a ? -acc_hi : acc_hi;
    assign mul_ovf  = sgn ? (prod_fix[W2-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})
                          : (prod_fix[W2-1:WIDTH] != {WIDTH{1'b0}});
    // Only MIN/-1 yields a magnitude quotient of MIN with both operands negative
    assign div_ovf  = neg_a & neg_b & (opnd_mag == WIDTH'(1)) & (acc_lo == MIN_NEG);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start_mul) begin
                    state_nx = S_MUL;
                end else if (start_div) begin
                    state_nx = (data_operandB == {WIDTH{1'b0}}) ? S_FIX : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_LAST) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_nx        = cnt;
        op_mul_nx     = op_mul;
        sgn_nx        = sgn;
        neg_a_nx      = neg_a;
        neg_b_nx      = neg_b;
        dbz_nx        = dbz;
        opnd_mag_nx   = opnd_mag;
        acc_hi_nx     = acc_hi;
        acc_lo_nx     = acc_lo;
        result_nx     = data_result;
        result_hi_nx  = data_result_hi;
        exception_nx  = data_exception;
        result_rdy_nx = 1'b0;
        mult_rdy_nx   = 1'b0;
        div_rdy_nx    = 1'b0;
        busy_nx       = busy;
        case (state)
            S_IDLE: begin
                busy_nx = 1'b0;
                if (start_mul | start_div) begin
                    busy_nx     = 1'b1;
                    op_mul_nx   = start_mul;
                    sgn_nx      = ctrl_signed;
                    neg_a_nx    = ctrl_signed & data_operandA[WIDTH-1];
                    neg_b_nx    = ctrl_signed & data_operandB[WIDTH-1];
                    cnt_nx      = {CNT_W{1'b0}};
                    dbz_nx      = ~start_mul & (data_operandB == {WIDTH{1'b0}});
                    opnd_mag_nx = start_mul ? a_mag : b_mag;
                    acc_lo_nx   = start_mul ? b_mag : a_mag;
                    // Divide-by-zero parks the raw dividend for the remainder output
                    acc_hi_nx   = (~start_mul & (data_operandB == {WIDTH{1'b0}}))
                                  ? data_operandA : {WIDTH{1'b0}};
                end
            end
            S_MUL: begin
                acc_hi_nx = mul_sum[WIDTH:1];
                acc_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
                cnt_nx    = cnt + CNT_W'(1);
            end
            S_DIV: begin
                if (div_ge) begin
                    acc_hi_nx = div_diff;
                    acc_lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_nx = div_shift[WIDTH-1:0];
                    acc_lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
                end
                cnt_nx = cnt + CNT_W'(1);
            end
            S_FIX: begin
                result_rdy_nx = 1'b1;
                mult_rdy_nx   = op_mul;
                div_rdy_nx    = ~op_mul;
                if (op_mul) begin
                    result_nx    = prod_fix[WIDTH-1:0];
                    result_hi_nx = prod_fix[W2-1:WIDTH];
                    exception_nx = mul_ovf;
                end else if (dbz) begin
                    result_nx    = {WIDTH{1'b0}};
                    result_hi_nx = acc_hi;
                    exception_nx = 1'b1;
                end else begin
                    result_nx    = quo_fix;
                    result_hi_nx = rem_fix;
                    exception_nx = div_ovf;
                end
            end
            default: ;
        endcase
    end

    // Datapath, edge-detect and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_mult      <= 1'b0;
            prev_div       <= 1'b0;
            cnt            <= {CNT_W{1'b0}};
            op_mul         <= 1'b0;
            sgn            <= 1'b0;
            neg_a          <= 1'b0;
            neg_b          <= 1'b0;
            dbz            <= 1'b0;
            opnd_mag       <= {WIDTH{1'b0}};
            acc_hi         <= {WIDTH{1'b0}};
            acc_lo         <= {WIDTH{1'b0}};
            data_result    <= {WIDTH{1'b0}};
            data_result_hi <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
            multRDY        <= 1'b0;
            divRDY         <= 1'b0;
        end else begin
            prev_mult      <= ctrl_MULT;
            prev_div       <= ctrl_DIV;
            cnt            <= cnt_nx;
            op_mul         <= op_mul_nx;
            sgn            <= sgn_nx;
            neg_a          <= neg_a_nx;
            neg_b          <= neg_b_nx;
            dbz            <= dbz_nx;
            opnd_mag       <= opnd_mag_nx;
            acc_hi         <= acc_hi_nx;
            acc_lo         <= acc_lo_nx;
            data_result    <= result_nx;
            data_result_hi <= result_hi_nx;
            data_exception <= exception_nx;
            data_resultRDY <= result_rdy_nx;
            busy           <= busy_nx;
            multRDY        <= mult_rdy_nx;
            divRDY         <= div_rdy_nx;
        end
    end

endmodule
